// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Round-robin arbiter for the shared memory-subsystem bus. Four masters
// (dcache, system-controller read master, icache, DMA) request the bus. At
// most one of them holds a registered one-hot grant at any time. A granted
// master signals that it has taken the bus by raising its busy line. It keeps
// the bus for as long as busy stays high.
//
// A watchdog revokes a grant that is not accepted within GNT_TIMEOUT cycles.
// Every change of owner passes through a one-cycle RELEASE state with
// grant = 0, which gives the bus a turnaround cycle.
//
// Parameters:
//   GNT_TIMEOUT  cycles a granted master may take to raise busy (1..2^CNTW-1)
//   CNTW         watchdog counter width
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   reset         synchronous, active-high
//   req[3:0]      bus request per master: [0] dcache, [1] sys, [2] icache,
//                 [3] dma
//   busy[3:0]     master i drives the bus while busy[i] = 1
//   grant[3:0]    registered one-hot grant; all zero when there is no owner
//   owner[1:0]    registered index of the current or last granted master
//   bus_busy      combinational OR of busy[3:0]
//   bus_idle      registered; 1 only while the arbiter is in IDLE
//   timeout       registered one-cycle pulse when the watchdog revokes a grant
//   protocol_err  registered one-cycle pulse after a cycle in which a master
//                 without the grant drove busy
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int GNT_TIMEOUT = 16,
    parameter int CNTW        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] busy,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       bus_busy,
    output logic       bus_idle,
    output logic       timeout,
    output logic       protocol_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        OWNED   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Count value reached on the last cycle a grant may remain unaccepted.
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(GNT_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            bus_idle_q, bus_idle_d;
    logic            timeout_q, timeout_d;
    logic            perr_q, perr_d;

    logic [1:0]      rr_ptr;
    logic [1:0]      win;

    // Scans ptr+1, ptr+2, ptr+3 and then ptr itself (modulo 4). It returns
    // the first index whose request bit is set. The master at ptr therefore
    // has the lowest priority. When no bit is set the result is not used.
    function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                               input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        logic [1:0] sel;
        sel   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // In RELEASE the pointer update and the next grant happen on the same
    // edge. The winner is therefore taken from the master that is leaving,
    // which is the value last is about to receive.
    always_comb begin
        rr_ptr = (state_q == RELEASE) ? owner_q : last_q;
        win    = pick_winner(req, rr_ptr);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        // A busy line from a master that does not hold the grant is only
        // reported. It has no effect on arbitration.
        perr_d    = |(busy & ~grant_q);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    grant_d = onehot(win);
                    owner_d = win;
                    cnt_d   = '0;
                end
            end

            GRANT: begin
                // Priority: acceptance, then abandonment, then watchdog expiry.
                // If busy rises on the expiry cycle, the grant counts as
                // accepted.
                if (busy[owner_q]) begin
                    state_d = OWNED;
                end else if (!req[owner_q]) begin
                    state_d = RELEASE;
                    grant_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            OWNED: begin
                // The owner keeps the bus as long as it wants to. There is no
                // preemption and no hold limit.
                if (!busy[owner_q]) begin
                    state_d = RELEASE;
                    grant_d = '0;
                end
            end

            RELEASE: begin
                last_d = owner_q;
                if (|req) begin
                    state_d = GRANT;
                    grant_d = onehot(win);
                    owner_d = win;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        bus_idle_d = (state_d == IDLE);
    end

    // Reset clears every register, including owner and grant. This makes a
    // master that is mid-transfer lose the bus on the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= 2'd0;
            last_q     <= 2'd3;
            cnt_q      <= '0;
            bus_idle_q <= 1'b1;
            timeout_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            bus_idle_q <= bus_idle_d;
            timeout_q  <= timeout_d;
            perr_q     <= perr_d;
        end
    end

    assign grant        = grant_q;
    assign owner        = owner_q;
    assign bus_idle     = bus_idle_q;
    assign timeout      = timeout_q;
    assign protocol_err = perr_q;
    assign bus_busy     = |busy;

    // Safety properties of the grant output.
    a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant_q));
    a_cnt_bounded   : assert property (@(posedge clk) cnt_q <= CNT_LAST);
    a_no_back2back  : assert property (@(posedge clk)
        ((grant_q != 4'b0) && ($past(grant_q) != 4'b0)) |-> (grant_q == $past(grant_q)));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       bus_busy;
    logic       bus_idle;
    logic       timeout;
    logic       protocol_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.GNT_TIMEOUT(T), .CNTW(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .busy         (busy),
        .grant        (grant),
        .owner        (owner),
        .bus_busy     (bus_busy),
        .bus_idle     (bus_idle),
        .timeout      (timeout),
        .protocol_err (protocol_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0;
        busy  = 4'b0;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] busy;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       idle;
        logic       tmo;
        logic       perr;
    } vec_t;

    vec_t tbl[18];

    // ---------------- reference model ----------------
    // The model tracks who holds the grant and whether that master has taken
    // the bus. It also tracks how long the grant has been waiting, and whether
    // the bus is in its turnaround cycle.
    int m_last, m_owner, m_age;
    bit m_granted, m_acc, m_turn, m_tmo, m_perr;

    function automatic logic [3:0] m_grant();
        return m_granted ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst, input logic [3:0] r, input logic [3:0] b);
        int w;
        m_perr = ((b & ~m_grant()) != 4'b0);
        m_tmo  = 1'b0;
        if (rst) begin
            m_last = 3; m_owner = 0; m_granted = 0; m_acc = 0; m_turn = 0;
            m_age = 0; m_perr = 0;
        end else if (m_turn || !m_granted) begin
            if (m_turn) m_last = m_owner;
            m_turn = 0;
            w = rr_pick(r, m_last);
            if (w >= 0) begin
                m_owner = w; m_granted = 1; m_acc = 0; m_age = 0;
            end
        end else if (!m_acc) begin
            if (b[m_owner]) m_acc = 1;
            else if (!r[m_owner]) begin m_granted = 0; m_turn = 1; end
            else if (m_age == T - 1) begin m_granted = 0; m_turn = 1; m_tmo = 1; end
            else m_age++;
        end else if (!b[m_owner]) begin
            m_granted = 0; m_acc = 0; m_turn = 1;
        end
    endtask

    initial begin
        logic [3:0] mg;
        bit         flag;
        bit         rst_r;
        int         seq[5];

        // ---- reset values ----
        do_reset();
        chk("rst grant", grant, 4'b0);
        chk("rst owner", owner, 2'd0);
        chk("rst idle", bus_idle, 1'b1);
        chk("rst timeout", timeout, 1'b0);
        chk("rst perr", protocol_err, 1'b0);

        // ---- table: idle request, own, release, abandon, protocol error, reset ----
        //           rst   req      busy     grant    own  idle tmo perr
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'b0001, 4'b0010, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].req;
            busy  = tbl[i].busy;
            tick();
            chk($sformatf("vec%0d grant", i), grant, tbl[i].grant);
            chk($sformatf("vec%0d owner", i), owner, tbl[i].owner);
            chk($sformatf("vec%0d idle", i), bus_idle, tbl[i].idle);
            chk($sformatf("vec%0d timeout", i), timeout, tbl[i].tmo);
            chk($sformatf("vec%0d perr", i), protocol_err, tbl[i].perr);
        end

        // ---- round robin with all masters requesting ----
        do_reset();
        seq = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("rr%0d grant", n), grant, 4'b0001 << seq[n]);
            chk($sformatf("rr%0d owner", n), owner, seq[n]);
            busy = 4'b0001 << seq[n];
            for (int c = 0; c < 3; c++) begin
                tick();
                chk($sformatf("rr%0d hold", n), grant, 4'b0001 << seq[n]);
            end
            busy = 4'b0;
            tick();
            chk($sformatf("rr%0d turnaround", n), grant, 4'b0);
            chk($sformatf("rr%0d perr", n), protocol_err, 1'b0);
            tick();
        end

        // ---- watchdog timeout and re-grant ----
        do_reset();
        req = 4'b1000;
        tick();
        for (int c = 1; c <= T; c++) begin
            chk($sformatf("wd c%0d grant", c), grant, 4'b1000);
            chk($sformatf("wd c%0d timeout", c), timeout, 1'b0);
            tick();
        end
        chk("wd expire timeout", timeout, 1'b1);
        chk("wd expire grant", grant, 4'b0);
        tick();
        chk("wd regrant grant", grant, 4'b1000);
        chk("wd regrant timeout", timeout, 1'b0);
        // busy arriving on the expiry cycle is an acceptance
        repeat (T - 1) tick();
        chk("wd late grant", grant, 4'b1000);
        busy = 4'b1000;
        tick();
        chk("wd late accept timeout", timeout, 1'b0);
        chk("wd late accept grant", grant, 4'b1000);
        tick();
        chk("wd owned grant", grant, 4'b1000);
        busy = 4'b0;
        req  = 4'b0;
        tick();
        chk("wd release grant", grant, 4'b0);
        tick();
        chk("wd idle", bus_idle, 1'b1);

        // ---- foreign busy while owned ----
        do_reset();
        req = 4'b0001;
        tick();
        busy = 4'b0001;
        tick();
        busy = 4'b0011;
        tick();
        chk("perr pulse", protocol_err, 1'b1);
        chk("perr grant kept", grant, 4'b0001);
        busy = 4'b0001;
        tick();
        chk("perr single", protocol_err, 1'b0);
        chk("perr grant still", grant, 4'b0001);

        // ---- reset in the middle of an owned transfer ----
        do_reset();
        req = 4'b0010;
        tick();
        chk("mid grant", grant, 4'b0010);
        busy = 4'b0010;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid rst grant", grant, 4'b0);
        chk("mid rst owner", owner, 2'd0);
        chk("mid rst idle", bus_idle, 1'b1);
        reset = 1'b0;
        busy  = 4'b0;
        req   = 4'b1111;
        tick();
        chk("mid after grant", grant, 4'b0001);

        // ---- randomized run against the model ----
        reset = 1'b1; req = 4'b0; busy = 4'b0;
        model_step(1'b1, req, busy);
        tick();
        reset = 1'b0;
        flag  = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_r = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 7) == 0) flag = ~flag;
            mg   = m_grant();
            busy = flag ? mg : 4'b0;
            if ($urandom_range(0, 39) == 0) busy[$urandom_range(0, 3)] = 1'b1;
            reset = rst_r;
            #1;
            chk("rnd bus_busy", bus_busy, |busy);
            model_step(rst_r, req, busy);
            tick();
            chk($sformatf("rnd%0d grant", cyc), grant, m_grant());
            chk($sformatf("rnd%0d owner", cyc), owner, m_owner);
            chk($sformatf("rnd%0d idle", cyc), bus_idle, !m_granted && !m_turn);
            chk($sformatf("rnd%0d timeout", cyc), timeout, m_tmo);
            chk($sformatf("rnd%0d perr", cyc), protocol_err, m_perr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
